// File: rtl/uart_alu_pkg.sv
// Shared opcode, status and state definitions for the UART/ALU command sequencer.
package uart_alu_pkg;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  localparam logic [7:0] ST_OK     = 8'h00;
  localparam logic [7:0] ST_BAD_OP = 8'hEE;

  typedef enum logic [2:0] {
    GET_A,
    GET_B,
    GET_OP,
    EXEC,
    SEND_ST,
    SEND_RES
  } state_t;

endpackage

// File: rtl/frame_timeout.sv
// Inter-byte watchdog: reloads on every accepted byte, counts down while waiting.
module frame_timeout #(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned NB_CNT = $clog2(TIMEOUT);
  localparam logic [NB_CNT-1:0] LOAD_VAL = NB_CNT'(TIMEOUT - 1);

  logic [NB_CNT-1:0] count;

  // Loaded with TIMEOUT-1 and run down to zero: zero is reached on the
  // TIMEOUT-th empty cycle after a byte, i.e. an up-count of TIMEOUT-1.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count <= '0;
    end else if (i_load) begin
      count <= LOAD_VAL;
    end else if (i_en && (count != '0)) begin
      count <= count - NB_CNT'(1);
    end
  end

  assign o_expired = (count == '0);

endmodule

// File: rtl/uart_alu_ctrl.sv
// Collects A, B, opcode from the RX FIFO, drives the ALU and returns status + result.
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OP   = 6,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_empty,
  input  logic [NB_DATA-1:0] i_rx_data,
  output logic               o_rd_uart,
  input  logic               i_tx_full,
  output logic               o_wr_uart,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic               o_busy
);

  state_t             state;
  logic [NB_DATA-1:0] a_reg;
  logic [NB_DATA-1:0] b_reg;
  logic [NB_DATA-1:0] status_reg;
  logic [NB_DATA-1:0] result_reg;
  logic [NB_DATA-1:0] tx_last;
  logic               op_ok;

  logic rx_state;
  logic wait_state;
  logic rx_take;
  logic tx_take;
  logic drop;
  logic expired;
  logic tmo_load;
  logic tmo_en;
  logic op_known;
  logic op_valid_now;

  always_comb begin
    rx_state   = (state == GET_A) || (state == GET_B) || (state == GET_OP);
    wait_state = (state == GET_B) || (state == GET_OP);
    rx_take    = !i_reset && rx_state && !i_rx_empty;
    tx_take    = !i_reset && ((state == SEND_ST) || (state == SEND_RES)) && !i_tx_full;
    drop       = !i_reset && wait_state && i_rx_empty && expired;
    tmo_load   = rx_take || drop;
    tmo_en     = wait_state && i_rx_empty;
  end

  always_comb begin
    op_known = 1'b0;
    case (i_rx_data[NB_OP-1:0])
      NB_OP'(OP_ADD), NB_OP'(OP_SUB), NB_OP'(OP_AND), NB_OP'(OP_OR),
      NB_OP'(OP_XOR), NB_OP'(OP_SRA), NB_OP'(OP_SRL), NB_OP'(OP_NOR): op_known = 1'b1;
      default: op_known = 1'b0;
    endcase
    op_valid_now = op_known && (i_rx_data[NB_DATA-1:NB_OP] == '0);
  end

  frame_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_frame_timeout (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_load    (tmo_load),
    .i_en      (tmo_en),
    .o_expired (expired)
  );

  // Operands are staged locally and only copied to the ALU on the opcode pop,
  // so a dropped partial frame leaves the ALU inputs untouched.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= GET_A;
      a_reg      <= '0;
      b_reg      <= '0;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      op_ok      <= 1'b0;
      status_reg <= '0;
      result_reg <= '0;
      tx_last    <= '0;
    end else begin
      case (state)
        GET_A: begin
          if (!i_rx_empty) begin
            a_reg <= i_rx_data;
            state <= GET_B;
          end
        end
        GET_B: begin
          if (!i_rx_empty) begin
            b_reg <= i_rx_data;
            state <= GET_OP;
          end else if (expired) begin
            state <= GET_A;
          end
        end
        GET_OP: begin
          if (!i_rx_empty) begin
            o_alu_a  <= a_reg;
            o_alu_b  <= b_reg;
            o_alu_op <= i_rx_data[NB_OP-1:0];
            op_ok    <= op_valid_now;
            state    <= EXEC;
          end else if (expired) begin
            state <= GET_A;
          end
        end
        EXEC: begin
          result_reg <= op_ok ? i_alu_result : '0;
          status_reg <= op_ok ? NB_DATA'(ST_OK) : NB_DATA'(ST_BAD_OP);
          state      <= SEND_ST;
        end
        SEND_ST: begin
          if (!i_tx_full) begin
            tx_last <= status_reg;
            state   <= SEND_RES;
          end
        end
        SEND_RES: begin
          if (!i_tx_full) begin
            tx_last <= result_reg;
            state   <= GET_A;
          end
        end
        default: state <= GET_A;
      endcase
    end
  end

  // The TX byte only changes in a write cycle; otherwise it shows the last byte written.
  always_comb begin
    o_tx_data = tx_last;
    if (tx_take) begin
      o_tx_data = (state == SEND_ST) ? status_reg : result_reg;
    end
  end

  assign o_rd_uart = rx_take;
  assign o_wr_uart = tx_take;
  assign o_busy    = (state != GET_A);

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Scoreboard bench: frames are queued into a modelled RX FIFO, expected TX bytes checked in order.
module tb_uart_alu_ctrl;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_rx_empty;
  logic [7:0] i_rx_data;
  logic       o_rd_uart;
  logic       i_tx_full;
  logic       o_wr_uart;
  logic [7:0] o_tx_data;
  logic [7:0] o_alu_a;
  logic [7:0] o_alu_b;
  logic [5:0] o_alu_op;
  logic [7:0] i_alu_result;
  logic       o_busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  logic        tx_full_req = 1'b0;

  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  int unsigned pop_cyc[$];
  int unsigned wr_cyc[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] st;
    logic [7:0] res;
  } frame_t;

  uart_alu_ctrl #(
    .NB_DATA(8),
    .NB_OP  (6),
    .TIMEOUT(8)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_rx_empty   (i_rx_empty),
    .i_rx_data    (i_rx_data),
    .o_rd_uart    (o_rd_uart),
    .i_tx_full    (i_tx_full),
    .o_wr_uart    (o_wr_uart),
    .o_tx_data    (o_tx_data),
    .o_alu_a      (o_alu_a),
    .o_alu_b      (o_alu_b),
    .o_alu_op     (o_alu_op),
    .i_alu_result (i_alu_result),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Reference ALU; unknown opcodes return a non-zero marker so forcing to 0 is visible.
  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
    case (op)
      6'b100000: alu_model = a + b;
      6'b100010: alu_model = a - b;
      6'b100100: alu_model = a & b;
      6'b100101: alu_model = a | b;
      6'b100110: alu_model = a ^ b;
      6'b000011: alu_model = $signed(a) >>> b;
      6'b000010: alu_model = a >> b;
      6'b100111: alu_model = ~(a | b);
      default:   alu_model = 8'hA5;
    endcase
  endfunction

  always_comb i_alu_result = alu_model(o_alu_a, o_alu_b, o_alu_op);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // RX/TX FIFO flag model.
  always @(negedge i_clk) begin
    #1;
    i_tx_full = tx_full_req;
    if (rx_q.size() != 0) begin
      i_rx_empty = 1'b0;
      i_rx_data  = rx_q[0];
    end else begin
      i_rx_empty = 1'b1;
    end
  end

  // Strobe monitor and scoreboard.
  always @(negedge i_clk) begin
    #2;
    cyc++;
    if (o_rd_uart) begin
      check_eq("rd_when_empty", {31'd0, i_rx_empty}, 32'd0);
      check_eq("rd_with_wr", {31'd0, o_wr_uart}, 32'd0);
      if (rx_q.size() != 0) void'(rx_q.pop_front());
      pop_cyc.push_back(cyc);
    end
    if (o_wr_uart) begin
      check_eq("wr_when_full", {31'd0, i_tx_full}, 32'd0);
      wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) check_eq("tx_unexpected", {24'd0, o_tx_data}, 32'h100);
      else check_eq("tx_data", {24'd0, o_tx_data}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic push_byte(input logic [7:0] b);
    rx_q.push_back(b);
  endtask

  task automatic send_frame(input frame_t f);
    rx_q.push_back(f.a);
    rx_q.push_back(f.b);
    rx_q.push_back(f.op);
    exp_q.push_back(f.st);
    exp_q.push_back(f.res);
  endtask

  task automatic wait_rx_drained(input int unsigned max_cyc);
    int unsigned n = 0;
    while (rx_q.size() != 0 && n < max_cyc) begin
      @(negedge i_clk); #3;
      n++;
    end
    check_eq("rx_drain_in_time", {31'd0, (n < max_cyc)}, 32'd1);
  endtask

  task automatic wait_done(input int unsigned max_cyc);
    int unsigned n = 0;
    while ((rx_q.size() != 0 || exp_q.size() != 0 || o_busy) && n < max_cyc) begin
      @(negedge i_clk); #3;
      n++;
    end
    check_eq("frame_done_in_time", {31'd0, (n < max_cyc)}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t      tbl[7];
    frame_t      f;
    logic [7:0]  held;
    int unsigned rel;

    i_reset    = 1'b1;
    i_rx_empty = 1'b1;
    i_rx_data  = 8'h00;
    i_tx_full  = 1'b0;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    #3;
    check_eq("rst_alu_a", {24'd0, o_alu_a}, 32'd0);
    check_eq("rst_alu_b", {24'd0, o_alu_b}, 32'd0);
    check_eq("rst_alu_op", {26'd0, o_alu_op}, 32'd0);
    check_eq("rst_tx_data", {24'd0, o_tx_data}, 32'd0);
    check_eq("rst_busy", {31'd0, o_busy}, 32'd0);
    check_eq("rst_wr", {31'd0, o_wr_uart}, 32'd0);
    check_eq("rst_rd", {31'd0, o_rd_uart}, 32'd0);

    // Full frame with latency checks.
    pop_cyc.delete(); wr_cyc.delete();
    f = '{8'h05, 8'h03, 8'h20, 8'h00, 8'h08};
    send_frame(f);
    wait_done(40);
    check_eq("f1_alu_a", {24'd0, o_alu_a}, 32'h05);
    check_eq("f1_alu_b", {24'd0, o_alu_b}, 32'h03);
    check_eq("f1_alu_op", {26'd0, o_alu_op}, 32'h20);
    check_eq("f1_pops", pop_cyc.size(), 32'd3);
    check_eq("f1_writes", wr_cyc.size(), 32'd2);
    if (pop_cyc.size() == 3 && wr_cyc.size() == 2) begin
      check_eq("f1_lat_status", wr_cyc[0] - pop_cyc[2], 32'd2);
      check_eq("f1_lat_result", wr_cyc[1] - pop_cyc[2], 32'd3);
    end

    // Back-to-back frames including both opcode rejections.
    tbl[0] = '{8'h05, 8'h03, 8'h3F, 8'hEE, 8'h00};
    tbl[1] = '{8'h05, 8'h03, 8'hA0, 8'hEE, 8'h00};
    tbl[2] = '{8'h03, 8'h05, 8'h22, 8'h00, 8'hFE};
    tbl[3] = '{8'hF0, 8'h02, 8'h03, 8'h00, 8'hFC};
    tbl[4] = '{8'hF0, 8'h04, 8'h02, 8'h00, 8'h0F};
    tbl[5] = '{8'h0F, 8'h30, 8'h27, 8'h00, 8'hC0};
    tbl[6] = '{8'hFF, 8'h0F, 8'h26, 8'h00, 8'hF0};
    pop_cyc.delete(); wr_cyc.delete();
    for (int i = 0; i < 7; i++) send_frame(tbl[i]);
    wait_done(200);
    check_eq("b2b_pops", pop_cyc.size(), 32'd21);
    if (pop_cyc.size() >= 4) check_eq("b2b_next_a", pop_cyc[3] - pop_cyc[2], 32'd4);

    // TX backpressure held across SEND_ST.
    tx_full_req = 1'b1;
    pop_cyc.delete(); wr_cyc.delete();
    f = '{8'h0F, 8'h30, 8'h25, 8'h00, 8'h3F};
    send_frame(f);
    wait_rx_drained(20);
    repeat (2) begin @(negedge i_clk); #3; end
    held = o_tx_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk); #3;
      check_eq("bp_no_write", {31'd0, o_wr_uart}, 32'd0);
      check_eq("bp_tx_stable", {24'd0, o_tx_data}, {24'd0, held});
      check_eq("bp_busy", {31'd0, o_busy}, 32'd1);
    end
    @(negedge i_clk);
    tx_full_req = 1'b0;
    rel = cyc + 1;
    wait_done(20);
    check_eq("bp_writes", wr_cyc.size(), 32'd2);
    if (wr_cyc.size() == 2) begin
      check_eq("bp_first_wr", wr_cyc[0], rel);
      check_eq("bp_second_wr", wr_cyc[1], rel + 1);
    end

    // Timeout: lone byte followed by 8 idle cycles is discarded.
    push_byte(8'h11);
    wait_rx_drained(20);
    repeat (9) @(negedge i_clk);
    check_eq("tmo_dropped", {31'd0, o_busy}, 32'd0);
    f = '{8'h22, 8'h33, 8'h24, 8'h00, 8'h22};
    send_frame(f);
    wait_done(40);
    check_eq("tmo_alu_a", {24'd0, o_alu_a}, 32'h22);
    check_eq("tmo_alu_b", {24'd0, o_alu_b}, 32'h33);

    // Gapped arrival: 7 empty cycles is the longest gap that survives.
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h3F);
    push_byte(8'h0F);
    wait_rx_drained(20);
    repeat (8) @(negedge i_clk);
    push_byte(8'h30);
    wait_rx_drained(20);
    repeat (4) @(negedge i_clk);
    push_byte(8'h26);
    wait_done(40);
    check_eq("gap_alu_a", {24'd0, o_alu_a}, 32'h0F);

    // Reset while waiting for the opcode.
    push_byte(8'h44);
    push_byte(8'h55);
    wait_rx_drained(20);
    @(negedge i_clk); #3;
    check_eq("mid_busy", {31'd0, o_busy}, 32'd1);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    #3;
    check_eq("mrst_alu_a", {24'd0, o_alu_a}, 32'd0);
    check_eq("mrst_alu_b", {24'd0, o_alu_b}, 32'd0);
    check_eq("mrst_alu_op", {26'd0, o_alu_op}, 32'd0);
    check_eq("mrst_tx_data", {24'd0, o_tx_data}, 32'd0);
    check_eq("mrst_busy", {31'd0, o_busy}, 32'd0);
    repeat (5) @(negedge i_clk);
    f = '{8'h0A, 8'h04, 8'h22, 8'h00, 8'h06};
    send_frame(f);
    wait_done(40);
    check_eq("mrst_new_a", {24'd0, o_alu_a}, 32'h0A);

    repeat (3) @(negedge i_clk);
    check_eq("sb_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
